eco32f_wb_arbiter: RTL and testbench
====================================

Name:
eco32f_wb_arbiter

Overview:
- Two-master, one-slave Wishbone arbiter that shares the single external memory bus between the instruction-fetch master (i-side: refill bursts) and the data master (d-side: loads/stores).
- Holds a grant for the whole cyc_o envelope, so 8-beat wrapping refill bursts are never split.
- Includes a bus-hang watchdog that terminates a stalled cycle with an error.
- Sits between eco32f_fetch / the data-memory unit and the top-level bus port.

Parameters:
- ROUND_ROBIN, 1: 1 = the last-granted master gets lowest priority; 0 = fixed, d-side always wins.
- TIMEOUT, 255: cycles stb may stay unacknowledged before the watchdog fires; 0 disables it.
- TO_WIDTH, 8: width of the watchdog counter; must satisfy TIMEOUT < 2^TO_WIDTH.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- iwbs_adr_i, dwbs_adr_i  in  32  master address
- iwbs_dat_i, dwbs_dat_i  in  32  master write data
- iwbs_sel_i, dwbs_sel_i  in  4  byte selects
- iwbs_we_i, dwbs_we_i, iwbs_cyc_i, dwbs_cyc_i, iwbs_stb_i, dwbs_stb_i  in  1  each: master control
- iwbs_cti_i, dwbs_cti_i  in  3; iwbs_bte_i, dwbs_bte_i  in  2  burst type
- iwbs_dat_o, dwbs_dat_o  out  32  read data (slave data broadcast to both)
- iwbs_ack_o, dwbs_ack_o, iwbs_err_o, dwbs_err_o, iwbs_rty_o, dwbs_rty_o  out  1  each: gated responses
- wbm_adr_o, wbm_dat_o  out  32; wbm_sel_o  out  4; wbm_cti_o  out  3; wbm_bte_o  out  2  to slave
- wbm_we_o, wbm_cyc_o, wbm_stb_o  out  1  to slave
- wbm_dat_i  in  32; wbm_ack_i, wbm_err_i, wbm_rty_i  in  1  from slave
- gnt  out  2  one-hot current owner: bit0 = i, bit1 = d; 00 when idle
- bus_timeout  out  1  one-cycle pulse when the watchdog fires

Behaviour:
- State machine: IDLE, GNT_I, GNT_D. Reset: state IDLE, gnt 00, last-granted = i (so d wins the first tie), watchdog 0, bus_timeout 0.
- Arbitration point: any cycle in IDLE, or in GNT_x while x's cyc_i = 0.
  - Requests are the cyc_i inputs.
  - The winner is registered and owns the bus from the next cycle (1-cycle grant latency).
  - No requests: next state IDLE.
  - GNT_x -> GNT_y with no idle gap is allowed.
- Tie-break:
  - ROUND_ROBIN = 1: the master not granted last wins.
  - ROUND_ROBIN = 0: d wins.
- Ownership:
  - An owner keeps the bus while its cyc_i = 1, regardless of the other master.
  - The owner may hold cyc with stb = 0; this is not a release.
- Slave outputs:
  - Owner's adr/dat/sel/we/cti/bte/cyc/stb are muxed combinationally from the registered state.
  - In IDLE: cyc = stb = we = 0 and cti = 0. adr/dat/sel hold the last owner's values; they are don't-care for verification.
  - The owner's cyc_i falling takes wbm_cyc_o low in the same cycle (combinational).
- Responses:
  - ack/err/rty go only to the owner, qualified by the owner's cyc_i.
  - The non-owner sees 0. Both see wbm_dat_i on dat_o.
  - A slave response arriving in IDLE is dropped.
- Watchdog:
  - Counter clears on grant change and on any ack/err/rty.
  - Increments while the owner's stb is high with no response.
  - When it reaches TIMEOUT (TIMEOUT != 0):
    - the owner receives err_o = 1 for exactly that cycle;
    - wbm_cyc_o/wbm_stb_o are forced 0 that cycle;
    - bus_timeout pulses; the counter clears;
    - the state goes to IDLE, with last-granted set to the faulting master.
  - After a watchdog err, the master must drop cyc (eco32f_fetch signals a bus fault).
- Simultaneous events:
  - Owner releases while both request: normal tie-break.
  - Slave ack in the same cycle the watchdog would fire: the ack wins, with no err or timeout.
- Reset mid-burst: cyc/stb drop in the same cycle rst is sampled; there is no completion.

Decomposition:
- eco32f.vh gains ECO32F_WB_CTI_CLASSIC (3'b000), ECO32F_WB_CTI_INCR (3'b010), ECO32F_WB_CTI_EOB (3'b111) and ECO32F_WB_BTE_WRAP8 (2'b10).
- The arbiter is a single flat module; no sub-module.

Test Plan:
- i-side 8-beat burst (cti 010x7 then 111, ack every cycle), d-side cyc raised at beat 2 -> gnt stays 01 through all 8 acks; d granted (gnt = 10) the cycle after i's cyc drops; dwbs_ack_o = 0 throughout the burst.
- Both cyc rise together at reset exit, ROUND_ROBIN = 1 -> gnt 10, then 01, then 10 on repeated single transfers; ROUND_ROBIN = 0 -> gnt 10 every time.
- d single write at adr 0x00001000, sel 4'b0011 -> wbm_adr_o = 0x00001000, wbm_we_o = 1, wbm_sel_o = 0011 one cycle after request; iwbs_* responses stay 0.
- TIMEOUT = 4, slave never acks i-side -> iwbs_err_o and bus_timeout high exactly on the 4th stb cycle; wbm_cyc_o = 0 that cycle; gnt = 00 next.
- Ack on the same cycle the count hits TIMEOUT -> ack delivered, no err, no bus_timeout.
- rst asserted mid d-burst at beat 3 -> wbm_cyc_o = 0 the same cycle; gnt = 00 after reset; no response is forwarded.

Source files
------------

// File: rtl/eco32f_wb_arbiter_pkg.sv
// +----------------------------------------------------------------------+
// | eco32f_wb_arbiter_pkg: Wishbone burst encodings and arbiter states    |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

package eco32f_wb_arbiter_pkg;

  localparam logic [2:0] ECO32F_WB_CTI_CLASSIC = 3'b000;
  localparam logic [2:0] ECO32F_WB_CTI_INCR    = 3'b010;
  localparam logic [2:0] ECO32F_WB_CTI_EOB     = 3'b111;
  localparam logic [1:0] ECO32F_WB_BTE_WRAP8   = 2'b10;

  // Encoding of the last-granted master.
  localparam logic c_master_i = 1'b0;
  localparam logic c_master_d = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GNT_I = 2'd1,
    ST_GNT_D = 2'd2
  } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/eco32f_wb_arbiter.sv
// +----------------------------------------------------------------------+
// | eco32f_wb_arbiter: two-master Wishbone arbiter with bus-hang watchdog |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

module eco32f_wb_arbiter
  import eco32f_wb_arbiter_pkg::*;
#(
  parameter int ROUND_ROBIN = 1,
  parameter int TIMEOUT     = 255,
  parameter int TO_WIDTH    = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] iwbs_adr_i,
  input  logic [31:0] iwbs_dat_i,
  input  logic [3:0]  iwbs_sel_i,
  input  logic        iwbs_we_i,
  input  logic        iwbs_cyc_i,
  input  logic        iwbs_stb_i,
  input  logic [2:0]  iwbs_cti_i,
  input  logic [1:0]  iwbs_bte_i,
  output logic [31:0] iwbs_dat_o,
  output logic        iwbs_ack_o,
  output logic        iwbs_err_o,
  output logic        iwbs_rty_o,
  input  logic [31:0] dwbs_adr_i,
  input  logic [31:0] dwbs_dat_i,
  input  logic [3:0]  dwbs_sel_i,
  input  logic        dwbs_we_i,
  input  logic        dwbs_cyc_i,
  input  logic        dwbs_stb_i,
  input  logic [2:0]  dwbs_cti_i,
  input  logic [1:0]  dwbs_bte_i,
  output logic [31:0] dwbs_dat_o,
  output logic        dwbs_ack_o,
  output logic        dwbs_err_o,
  output logic        dwbs_rty_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  output logic [3:0]  wbm_sel_o,
  output logic        wbm_we_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic [2:0]  wbm_cti_o,
  output logic [1:0]  wbm_bte_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i,
  input  logic        wbm_err_i,
  input  logic        wbm_rty_i,
  output logic [1:0]  gnt,
  output logic        bus_timeout
);

  localparam bit c_to_en = (TIMEOUT != 0);
  localparam bit c_fixed = (ROUND_ROBIN == 0);
  localparam logic [TO_WIDTH-1:0] c_to_last = TO_WIDTH'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  arb_state_t          r_state, w_state_next;
  logic                r_last, w_last_next;
  logic [TO_WIDTH-1:0] r_wdog, w_wdog_next;

  logic w_own_i, w_own_d, w_sel_d, w_own_cyc, w_own_stb, w_resp, w_fire, w_gate;

  assign w_own_i   = (r_state == ST_GNT_I);
  assign w_own_d   = (r_state == ST_GNT_D);
  // When idle the data-path mux parks on whoever owned the bus last.
  assign w_sel_d   = w_own_d | ((r_state == ST_IDLE) & (r_last == c_master_d));
  assign w_own_cyc = (w_own_i & iwbs_cyc_i) | (w_own_d & dwbs_cyc_i);
  assign w_own_stb = (w_own_i & iwbs_stb_i) | (w_own_d & dwbs_stb_i);
  assign w_resp    = wbm_ack_i | wbm_err_i | wbm_rty_i;
  // A real slave response in the firing cycle takes precedence over the watchdog.
  assign w_fire    = c_to_en & w_own_cyc & w_own_stb & ~w_resp & (r_wdog == c_to_last);
  assign w_gate    = ~rst & ~w_fire;

  assign wbm_adr_o = w_sel_d ? dwbs_adr_i : iwbs_adr_i;
  assign wbm_dat_o = w_sel_d ? dwbs_dat_i : iwbs_dat_i;
  assign wbm_sel_o = w_sel_d ? dwbs_sel_i : iwbs_sel_i;
  assign wbm_bte_o = w_sel_d ? dwbs_bte_i : iwbs_bte_i;
  assign wbm_cti_o = w_own_i ? iwbs_cti_i : (w_own_d ? dwbs_cti_i : ECO32F_WB_CTI_CLASSIC);
  assign wbm_we_o  = (w_own_i & iwbs_we_i) | (w_own_d & dwbs_we_i);
  assign wbm_cyc_o = w_own_cyc & w_gate;
  assign wbm_stb_o = w_own_cyc & w_own_stb & w_gate;

  assign iwbs_dat_o = wbm_dat_i;
  assign dwbs_dat_o = wbm_dat_i;
  assign iwbs_ack_o = w_own_i & iwbs_cyc_i & ~rst & wbm_ack_i;
  assign iwbs_err_o = w_own_i & iwbs_cyc_i & ~rst & (wbm_err_i | w_fire);
  assign iwbs_rty_o = w_own_i & iwbs_cyc_i & ~rst & wbm_rty_i;
  assign dwbs_ack_o = w_own_d & dwbs_cyc_i & ~rst & wbm_ack_i;
  assign dwbs_err_o = w_own_d & dwbs_cyc_i & ~rst & (wbm_err_i | w_fire);
  assign dwbs_rty_o = w_own_d & dwbs_cyc_i & ~rst & wbm_rty_i;

  assign gnt         = {w_own_d, w_own_i};
  assign bus_timeout = w_fire & ~rst;

  always_comb begin
    w_state_next = r_state;
    w_last_next  = r_last;
    w_wdog_next  = r_wdog;
    if (w_fire) begin
      w_state_next = ST_IDLE;
      w_last_next  = w_own_d ? c_master_d : c_master_i;
    end else if (!w_own_cyc) begin
      // Arbitration point: idle, or the owner has released cyc.
      if (dwbs_cyc_i && (!iwbs_cyc_i || c_fixed || (r_last == c_master_i))) begin
        w_state_next = ST_GNT_D;
        w_last_next  = c_master_d;
      end else if (iwbs_cyc_i) begin
        w_state_next = ST_GNT_I;
        w_last_next  = c_master_i;
      end else begin
        w_state_next = ST_IDLE;
      end
    end
    if (w_fire || w_resp || (w_state_next != r_state)) begin
      w_wdog_next = '0;
    end else if (c_to_en && w_own_cyc && w_own_stb) begin
      w_wdog_next = r_wdog + TO_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_last  <= c_master_i;
      r_wdog  <= '0;
    end else begin
      r_state <= w_state_next;
      r_last  <= w_last_next;
      r_wdog  <= w_wdog_next;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_eco32f_wb_arbiter.sv
// +----------------------------------------------------------------------+
// | tb_eco32f_wb_arbiter: directed bench, round-robin/TIMEOUT=4 instance  |
// | plus fixed-priority/no-watchdog instance on shared stimulus.         |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_eco32f_wb_arbiter;
  import eco32f_wb_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [31:0] iwbs_adr_i, iwbs_dat_i, dwbs_adr_i, dwbs_dat_i, wbm_dat_i;
  logic [3:0]  iwbs_sel_i, dwbs_sel_i;
  logic        iwbs_we_i, iwbs_cyc_i, iwbs_stb_i, dwbs_we_i, dwbs_cyc_i, dwbs_stb_i;
  logic [2:0]  iwbs_cti_i, dwbs_cti_i;
  logic [1:0]  iwbs_bte_i, dwbs_bte_i;
  logic        wbm_ack_i, wbm_err_i, wbm_rty_i;

  logic [31:0] iwbs_dat_o, dwbs_dat_o, wbm_adr_o, wbm_dat_o;
  logic        iwbs_ack_o, iwbs_err_o, iwbs_rty_o, dwbs_ack_o, dwbs_err_o, dwbs_rty_o;
  logic [3:0]  wbm_sel_o;
  logic        wbm_we_o, wbm_cyc_o, wbm_stb_o, bus_timeout;
  logic [2:0]  wbm_cti_o;
  logic [1:0]  wbm_bte_o, gnt;

  logic [31:0] b_iwbs_dat_o, b_dwbs_dat_o, b_wbm_adr_o, b_wbm_dat_o;
  logic        b_iwbs_ack_o, b_iwbs_err_o, b_iwbs_rty_o, b_dwbs_ack_o, b_dwbs_err_o, b_dwbs_rty_o;
  logic [3:0]  b_wbm_sel_o;
  logic        b_wbm_we_o, b_wbm_cyc_o, b_wbm_stb_o, b_bus_timeout;
  logic [2:0]  b_wbm_cti_o;
  logic [1:0]  b_wbm_bte_o, b_gnt;

  int checks = 0;
  int failures = 0;

  eco32f_wb_arbiter #(.ROUND_ROBIN(1), .TIMEOUT(4), .TO_WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .iwbs_adr_i(iwbs_adr_i), .iwbs_dat_i(iwbs_dat_i), .iwbs_sel_i(iwbs_sel_i), .iwbs_we_i(iwbs_we_i),
    .iwbs_cyc_i(iwbs_cyc_i), .iwbs_stb_i(iwbs_stb_i), .iwbs_cti_i(iwbs_cti_i), .iwbs_bte_i(iwbs_bte_i),
    .iwbs_dat_o(iwbs_dat_o), .iwbs_ack_o(iwbs_ack_o), .iwbs_err_o(iwbs_err_o), .iwbs_rty_o(iwbs_rty_o),
    .dwbs_adr_i(dwbs_adr_i), .dwbs_dat_i(dwbs_dat_i), .dwbs_sel_i(dwbs_sel_i), .dwbs_we_i(dwbs_we_i),
    .dwbs_cyc_i(dwbs_cyc_i), .dwbs_stb_i(dwbs_stb_i), .dwbs_cti_i(dwbs_cti_i), .dwbs_bte_i(dwbs_bte_i),
    .dwbs_dat_o(dwbs_dat_o), .dwbs_ack_o(dwbs_ack_o), .dwbs_err_o(dwbs_err_o), .dwbs_rty_o(dwbs_rty_o),
    .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_sel_o(wbm_sel_o), .wbm_we_o(wbm_we_o),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_cti_o(wbm_cti_o), .wbm_bte_o(wbm_bte_o),
    .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i), .wbm_rty_i(wbm_rty_i),
    .gnt(gnt), .bus_timeout(bus_timeout)
  );

  eco32f_wb_arbiter #(.ROUND_ROBIN(0), .TIMEOUT(0), .TO_WIDTH(8)) dut_fixed (
    .clk(clk), .rst(rst),
    .iwbs_adr_i(iwbs_adr_i), .iwbs_dat_i(iwbs_dat_i), .iwbs_sel_i(iwbs_sel_i), .iwbs_we_i(iwbs_we_i),
    .iwbs_cyc_i(iwbs_cyc_i), .iwbs_stb_i(iwbs_stb_i), .iwbs_cti_i(iwbs_cti_i), .iwbs_bte_i(iwbs_bte_i),
    .iwbs_dat_o(b_iwbs_dat_o), .iwbs_ack_o(b_iwbs_ack_o), .iwbs_err_o(b_iwbs_err_o), .iwbs_rty_o(b_iwbs_rty_o),
    .dwbs_adr_i(dwbs_adr_i), .dwbs_dat_i(dwbs_dat_i), .dwbs_sel_i(dwbs_sel_i), .dwbs_we_i(dwbs_we_i),
    .dwbs_cyc_i(dwbs_cyc_i), .dwbs_stb_i(dwbs_stb_i), .dwbs_cti_i(dwbs_cti_i), .dwbs_bte_i(dwbs_bte_i),
    .dwbs_dat_o(b_dwbs_dat_o), .dwbs_ack_o(b_dwbs_ack_o), .dwbs_err_o(b_dwbs_err_o), .dwbs_rty_o(b_dwbs_rty_o),
    .wbm_adr_o(b_wbm_adr_o), .wbm_dat_o(b_wbm_dat_o), .wbm_sel_o(b_wbm_sel_o), .wbm_we_o(b_wbm_we_o),
    .wbm_cyc_o(b_wbm_cyc_o), .wbm_stb_o(b_wbm_stb_o), .wbm_cti_o(b_wbm_cti_o), .wbm_bte_o(b_wbm_bte_o),
    .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i), .wbm_rty_i(wbm_rty_i),
    .gnt(b_gnt), .bus_timeout(b_bus_timeout)
  );

  task automatic idle_inputs();
    iwbs_adr_i = '0; iwbs_dat_i = '0; iwbs_sel_i = '0; iwbs_we_i = 0; iwbs_cyc_i = 0; iwbs_stb_i = 0;
    iwbs_cti_i = '0; iwbs_bte_i = '0;
    dwbs_adr_i = '0; dwbs_dat_i = '0; dwbs_sel_i = '0; dwbs_we_i = 0; dwbs_cyc_i = 0; dwbs_stb_i = 0;
    dwbs_cti_i = '0; dwbs_bte_i = '0;
    wbm_dat_i = '0; wbm_ack_i = 0; wbm_err_i = 0; wbm_rty_i = 0;
  endtask

  task automatic do_reset();
    @(negedge clk); idle_inputs(); rst = 1;
    @(negedge clk); rst = 0;
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 time unit later.
  task automatic test_reset();
    @(negedge clk); idle_inputs(); rst = 1;
    iwbs_cyc_i = 1; iwbs_stb_i = 1; dwbs_cyc_i = 1; dwbs_stb_i = 1; wbm_ack_i = 1;
    @(negedge clk); #1;
    checks++; if (gnt !== 2'b00) begin failures++; $display("FAIL reset_gnt got %b exp 00", gnt); end
    checks++; if (b_gnt !== 2'b00) begin failures++; $display("FAIL reset_gnt_fixed got %b exp 00", b_gnt); end
    checks++; if (wbm_cyc_o !== 1'b0 || wbm_stb_o !== 1'b0) begin failures++; $display("FAIL reset_cyc_stb got %b%b exp 00", wbm_cyc_o, wbm_stb_o); end
    checks++; if (bus_timeout !== 1'b0) begin failures++; $display("FAIL reset_timeout got %b exp 0", bus_timeout); end
    checks++; if (iwbs_ack_o !== 1'b0 || dwbs_ack_o !== 1'b0) begin failures++; $display("FAIL reset_ack got %b%b exp 00", iwbs_ack_o, dwbs_ack_o); end
    idle_inputs(); rst = 0;
  endtask

  task automatic test_burst();
    logic [31:0] exp_adr;
    logic [2:0]  exp_cti;
    do_reset();
    @(negedge clk);
    iwbs_cyc_i = 1; iwbs_stb_i = 1; iwbs_cti_i = ECO32F_WB_CTI_INCR; iwbs_bte_i = ECO32F_WB_BTE_WRAP8;
    iwbs_adr_i = 32'h0000_0214; #1;
    checks++; if (gnt !== 2'b00 || wbm_cyc_o !== 1'b0) begin failures++; $display("FAIL burst_latency gnt %b cyc %b exp 00 0", gnt, wbm_cyc_o); end
    for (int b = 0; b < 8; b++) begin
      @(negedge clk);
      exp_adr = 32'h0000_0200 | 32'(((b + 5) % 8) * 4);
      exp_cti = (b == 7) ? ECO32F_WB_CTI_EOB : ECO32F_WB_CTI_INCR;
      iwbs_adr_i = exp_adr; iwbs_cti_i = exp_cti;
      wbm_ack_i = 1; wbm_dat_i = 32'hA000_0000 + 32'(b);
      if (b == 2) begin dwbs_cyc_i = 1; dwbs_stb_i = 1; dwbs_adr_i = 32'h0000_3000; end
      #1;
      checks++; if (gnt !== 2'b01) begin failures++; $display("FAIL burst_gnt beat %0d got %b exp 01", b, gnt); end
      checks++; if (iwbs_ack_o !== 1'b1 || dwbs_ack_o !== 1'b0) begin failures++; $display("FAIL burst_ack beat %0d got i%b d%b exp i1 d0", b, iwbs_ack_o, dwbs_ack_o); end
      checks++; if (wbm_adr_o !== exp_adr) begin failures++; $display("FAIL burst_adr beat %0d got %h exp %h", b, wbm_adr_o, exp_adr); end
      checks++; if (wbm_cti_o !== exp_cti || wbm_bte_o !== 2'b10) begin failures++; $display("FAIL burst_cti beat %0d got %b/%b exp %b/10", b, wbm_cti_o, wbm_bte_o, exp_cti); end
      checks++; if (iwbs_dat_o !== 32'hA000_0000 + 32'(b)) begin failures++; $display("FAIL burst_dat beat %0d got %h", b, iwbs_dat_o); end
    end
    @(negedge clk); iwbs_cyc_i = 0; iwbs_stb_i = 0; wbm_ack_i = 0; #1;
    checks++; if (gnt !== 2'b01 || wbm_cyc_o !== 1'b0) begin failures++; $display("FAIL burst_release gnt %b cyc %b exp 01 0", gnt, wbm_cyc_o); end
    @(negedge clk); wbm_ack_i = 1; #1;
    checks++; if (gnt !== 2'b10) begin failures++; $display("FAIL burst_handover got %b exp 10", gnt); end
    checks++; if (wbm_cyc_o !== 1'b1 || wbm_adr_o !== 32'h0000_3000) begin failures++; $display("FAIL burst_d_bus cyc %b adr %h exp 1 00003000", wbm_cyc_o, wbm_adr_o); end
    checks++; if (dwbs_ack_o !== 1'b1 || iwbs_ack_o !== 1'b0) begin failures++; $display("FAIL burst_d_ack got d%b i%b exp d1 i0", dwbs_ack_o, iwbs_ack_o); end
    @(negedge clk); idle_inputs();
  endtask

  task automatic test_dwrite();
    do_reset();
    @(negedge clk);
    dwbs_cyc_i = 1; dwbs_stb_i = 1; dwbs_we_i = 1; dwbs_adr_i = 32'h0000_1000;
    dwbs_sel_i = 4'b0011; dwbs_dat_i = 32'h1234_5678; #1;
    checks++; if (gnt !== 2'b00) begin failures++; $display("FAIL dwrite_latency got %b exp 00", gnt); end
    @(negedge clk); wbm_ack_i = 1; wbm_dat_i = 32'h5A5A_0000; #1;
    checks++; if (gnt !== 2'b10) begin failures++; $display("FAIL dwrite_gnt got %b exp 10", gnt); end
    checks++; if (wbm_adr_o !== 32'h0000_1000 || wbm_sel_o !== 4'b0011) begin failures++; $display("FAIL dwrite_adr_sel got %h/%b exp 00001000/0011", wbm_adr_o, wbm_sel_o); end
    checks++; if (wbm_we_o !== 1'b1 || wbm_dat_o !== 32'h1234_5678) begin failures++; $display("FAIL dwrite_we_dat got %b/%h exp 1/12345678", wbm_we_o, wbm_dat_o); end
    checks++; if (dwbs_ack_o !== 1'b1) begin failures++; $display("FAIL dwrite_ack got %b exp 1", dwbs_ack_o); end
    checks++; if ({iwbs_ack_o, iwbs_err_o, iwbs_rty_o} !== 3'b000) begin failures++; $display("FAIL dwrite_i_quiet got %b exp 000", {iwbs_ack_o, iwbs_err_o, iwbs_rty_o}); end
    checks++; if (iwbs_dat_o !== 32'h5A5A_0000 || dwbs_dat_o !== 32'h5A5A_0000) begin failures++; $display("FAIL dwrite_broadcast got %h/%h exp 5a5a0000", iwbs_dat_o, dwbs_dat_o); end
    @(negedge clk); wbm_ack_i = 0; wbm_rty_i = 1; #1;
    checks++; if (dwbs_rty_o !== 1'b1 || iwbs_rty_o !== 1'b0 || dwbs_ack_o !== 1'b0) begin failures++; $display("FAIL dwrite_rty got d%b i%b ack%b exp 1 0 0", dwbs_rty_o, iwbs_rty_o, dwbs_ack_o); end
    @(negedge clk); wbm_rty_i = 0; wbm_err_i = 1; #1;
    checks++; if (dwbs_err_o !== 1'b1 || iwbs_err_o !== 1'b0 || bus_timeout !== 1'b0) begin failures++; $display("FAIL dwrite_err got d%b i%b to%b exp 1 0 0", dwbs_err_o, iwbs_err_o, bus_timeout); end
    @(negedge clk); idle_inputs();
  endtask

  task automatic test_watchdog();
    do_reset();
    @(negedge clk); iwbs_cyc_i = 1; iwbs_stb_i = 1; iwbs_adr_i = 32'h0000_0040;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk); #1;
      checks++; if (iwbs_err_o !== 1'b0 || bus_timeout !== 1'b0 || wbm_cyc_o !== 1'b1) begin failures++; $display("FAIL wdog_early stb cycle %0d err %b to %b cyc %b exp 0 0 1", c, iwbs_err_o, bus_timeout, wbm_cyc_o); end
    end
    @(negedge clk); #1;
    checks++; if (iwbs_err_o !== 1'b1 || bus_timeout !== 1'b1) begin failures++; $display("FAIL wdog_fire err %b to %b exp 1 1", iwbs_err_o, bus_timeout); end
    checks++; if (wbm_cyc_o !== 1'b0 || wbm_stb_o !== 1'b0) begin failures++; $display("FAIL wdog_cyc_forced cyc %b stb %b exp 0 0", wbm_cyc_o, wbm_stb_o); end
    checks++; if (dwbs_err_o !== 1'b0) begin failures++; $display("FAIL wdog_d_err got %b exp 0", dwbs_err_o); end
    checks++; if (b_iwbs_err_o !== 1'b0 || b_bus_timeout !== 1'b0 || b_wbm_cyc_o !== 1'b1) begin failures++; $display("FAIL wdog_disabled err %b to %b cyc %b exp 0 0 1", b_iwbs_err_o, b_bus_timeout, b_wbm_cyc_o); end
    @(negedge clk); idle_inputs(); #1;
    checks++; if (gnt !== 2'b00 || bus_timeout !== 1'b0) begin failures++; $display("FAIL wdog_after gnt %b to %b exp 00 0", gnt, bus_timeout); end
  endtask

  task automatic test_ack_race();
    do_reset();
    @(negedge clk); iwbs_cyc_i = 1; iwbs_stb_i = 1;
    for (int c = 1; c <= 3; c++) @(negedge clk);
    @(negedge clk); wbm_ack_i = 1; #1;
    checks++; if (iwbs_ack_o !== 1'b1 || iwbs_err_o !== 1'b0 || bus_timeout !== 1'b0) begin failures++; $display("FAIL race_ack ack %b err %b to %b exp 1 0 0", iwbs_ack_o, iwbs_err_o, bus_timeout); end
    checks++; if (wbm_cyc_o !== 1'b1) begin failures++; $display("FAIL race_cyc got %b exp 1", wbm_cyc_o); end
    @(negedge clk); wbm_ack_i = 0; #1;
    checks++; if (gnt !== 2'b01 || iwbs_err_o !== 1'b0 || bus_timeout !== 1'b0) begin failures++; $display("FAIL race_after gnt %b err %b to %b exp 01 0 0", gnt, iwbs_err_o, bus_timeout); end
    @(negedge clk); idle_inputs();
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_rr;
    do_reset();
    for (int r = 0; r < 3; r++) begin
      exp_rr = (r == 1) ? 2'b01 : 2'b10;
      @(negedge clk); iwbs_cyc_i = 1; iwbs_stb_i = 1; dwbs_cyc_i = 1; dwbs_stb_i = 1;
      @(negedge clk); wbm_ack_i = 1; #1;
      checks++; if (gnt !== exp_rr) begin failures++; $display("FAIL rr_gnt round %0d got %b exp %b", r, gnt, exp_rr); end
      checks++; if (b_gnt !== 2'b10) begin failures++; $display("FAIL fixed_gnt round %0d got %b exp 10", r, b_gnt); end
      checks++; if ({dwbs_ack_o, iwbs_ack_o} !== exp_rr) begin failures++; $display("FAIL rr_ack round %0d got %b exp %b", r, {dwbs_ack_o, iwbs_ack_o}, exp_rr); end
      @(negedge clk); idle_inputs(); #1;
      checks++; if (wbm_cyc_o !== 1'b0) begin failures++; $display("FAIL rr_release round %0d cyc %b exp 0", r, wbm_cyc_o); end
    end
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    @(negedge clk); dwbs_cyc_i = 1; dwbs_stb_i = 1; dwbs_cti_i = ECO32F_WB_CTI_INCR; dwbs_bte_i = ECO32F_WB_BTE_WRAP8;
    for (int b = 0; b < 3; b++) begin
      @(negedge clk); wbm_ack_i = 1; #1;
      checks++; if (gnt !== 2'b10 || dwbs_ack_o !== 1'b1) begin failures++; $display("FAIL midrst_beat %0d gnt %b ack %b exp 10 1", b, gnt, dwbs_ack_o); end
    end
    @(negedge clk); rst = 1; #1;
    checks++; if (wbm_cyc_o !== 1'b0 || wbm_stb_o !== 1'b0) begin failures++; $display("FAIL midrst_cyc cyc %b stb %b exp 0 0", wbm_cyc_o, wbm_stb_o); end
    checks++; if (dwbs_ack_o !== 1'b0 || iwbs_ack_o !== 1'b0) begin failures++; $display("FAIL midrst_ack d%b i%b exp 0 0", dwbs_ack_o, iwbs_ack_o); end
    @(negedge clk); rst = 0; idle_inputs(); #1;
    checks++; if (gnt !== 2'b00 || b_gnt !== 2'b00) begin failures++; $display("FAIL midrst_gnt got %b/%b exp 00/00", gnt, b_gnt); end
  endtask

  initial begin
    #200000;
    $display("FAIL global_time_limit reached without finishing");
    $fatal(1, "time limit");
  end

  initial begin
    rst = 1;
    idle_inputs();
    test_reset();
    test_burst();
    test_dwrite();
    test_watchdog();
    test_ack_race();
    test_round_robin();
    test_reset_mid_burst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
